mips_avalon_arbiter: RTL and testbench

//  Single Avalon-MM master shared by the cache write-buffer drain port and the cache read-miss port.

---
 rtl/mips_avalon_pkg.sv | 19 +
 rtl/mips_avalon_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_avalon_pkg.sv
// mips_avalon_pkg
//   Shared types and widths for the Avalon-MM arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE, WRITE, READ)
//   AVM_ADDR_W  : Avalon address width
//   AVM_DATA_W  : Avalon data width
//   AVM_BE_W    : Avalon byte-enable width
package mips_avalon_pkg;

    localparam int AVM_ADDR_W = 32;
    localparam int AVM_DATA_W = 32;
    localparam int AVM_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter
//   Single Avalon-MM master shared by the cache write-buffer drain port and
//   the cache read-miss port. One transfer at a time: IDLE picks a request and
//   latches it into the avm_* registers, WRITE/READ hold the bus until the
//   slave drops avm_waitrequest, then the FSM returns to IDLE.
//
//   Optional feature macro: MIPS_ARB_READ_PRIORITY_EN
//     undefined : write-first policy; a read is granted only when the write
//                 buffer is empty, so reads never pass buffered writes.
//     defined   : read-first policy with a 3-bit saturating burst counter;
//                 after READ_BURST_MAX consecutive reads a pending write wins.
//
//   Ports
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     wb_addr/writedata/byteenable/write/empty   write-buffer head
//     wb_waitrequest    low for one cycle = head consumed (buffer pops)
//     rd_addr, rd_read  read-miss request, held until rd_waitrequest low
//     rd_waitrequest    low for one cycle = read accepted by the bus
//     rd_readdata       registered read data
//     rd_readvalid      one-cycle pulse, rd_readdata valid
//     avm_*             Avalon-MM master interface
//
//   Handshake: a request (wb_write or rd_read) is a valid that must stay
//   asserted with stable payload until its waitrequest is sampled low at a
//   rising edge; that edge is the only transfer point. On the bus side the
//   avm_* outputs are held stable while avm_waitrequest is high, and the
//   transfer completes on the edge where avm_waitrequest is low.
module mips_avalon_arbiter
    import mips_avalon_pkg::*;
#(
    parameter int READ_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AVM_ADDR_W-1:0] wb_addr,
    input  logic [AVM_DATA_W-1:0] wb_writedata,
    input  logic [AVM_BE_W-1:0]   wb_byteenable,
    input  logic                  wb_write,
    input  logic                  wb_empty,
    output logic                  wb_waitrequest,
    input  logic [AVM_ADDR_W-1:0] rd_addr,
    input  logic                  rd_read,
    output logic                  rd_waitrequest,
    output logic [AVM_DATA_W-1:0] rd_readdata,
    output logic                  rd_readvalid,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [AVM_DATA_W-1:0] avm_writedata,
    output logic [AVM_BE_W-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata
);

    // The burst counter is 3 bits wide, so the limit must fit in it.
    if (READ_BURST_MAX < 1 || READ_BURST_MAX > 7) begin : g_param_check
        $error("READ_BURST_MAX must be in 1..7");
    end

    // Current FSM state, visible by name for debug and checkers.
    arb_state_t state;
    arb_state_t state_d;
    logic       grant_wr;
    logic       grant_rd;

`ifdef MIPS_ARB_READ_PRIORITY_EN
    logic [2:0] burst_cnt;
    logic       burst_at_max;

    assign burst_at_max = (burst_cnt >= 3'(READ_BURST_MAX));

    // Consecutive granted reads; any granted write starts a new burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= 3'd0;
        end else if (grant_wr) begin
            burst_cnt <= 3'd0;
        end else if (grant_rd && burst_cnt != 3'd7) begin
            burst_cnt <= burst_cnt + 3'd1;
        end
    end
`endif

    // Next-state and grant decode.
    always_comb begin
        state_d  = state;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        case (state)
            IDLE: begin
`ifdef MIPS_ARB_READ_PRIORITY_EN
                if (rd_read && !(burst_at_max && wb_write)) begin
                    grant_rd = 1'b1;
                end else if (wb_write) begin
                    grant_wr = 1'b1;
                end
`else
                // A read waits for the buffer to drain: no read may pass a
                // buffered write to the same line.
                if (wb_write) begin
                    grant_wr = 1'b1;
                end else if (rd_read && wb_empty) begin
                    grant_rd = 1'b1;
                end
`endif
                if (grant_wr) begin
                    state_d = WRITE;
                end else if (grant_rd) begin
                    state_d = READ;
                end
            end
            WRITE: if (!avm_waitrequest) state_d = IDLE;
            READ:  if (!avm_waitrequest) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Acceptance is combinational so the requester sees it on the same edge
    // the slave takes the transfer.
    assign wb_waitrequest = !((state == WRITE) && !avm_waitrequest);
    assign rd_waitrequest = !((state == READ)  && !avm_waitrequest);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            rd_readdata    <= '0;
            rd_readvalid   <= 1'b0;
        end else begin
            state        <= state_d;
            rd_readvalid <= 1'b0;
            if (grant_wr) begin
                avm_address    <= wb_addr;
                avm_writedata  <= wb_writedata;
                avm_byteenable <= wb_byteenable;
                avm_write      <= 1'b1;
            end else if (grant_rd) begin
                avm_address    <= rd_addr;
                avm_byteenable <= '1;
                avm_read       <= 1'b1;
            end
            if (state == WRITE && !avm_waitrequest) begin
                avm_write <= 1'b0;
            end
            if (state == READ && !avm_waitrequest) begin
                avm_read     <= 1'b0;
                rd_readdata  <= avm_readdata;
                rd_readvalid <= 1'b1;
            end
        end
    end

    // A read request may only be withdrawn on the edge that accepts it.
    a_rd_read_held: assert property (@(posedge clk) disable iff (rst)
        (rd_read && rd_waitrequest) |=> rd_read);

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
module tb_mips_avalon_arbiter;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_addr, wb_writedata, rd_addr, rd_readdata;
  logic [3:0]  wb_byteenable, avm_byteenable;
  logic        wb_write, wb_empty, wb_waitrequest;
  logic        rd_read, rd_waitrequest, rd_readvalid;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];      // expected rd_readdata, in order
  logic [32:0] exp_op_q[$];   // expected bus ops {is_write, address}
  logic [67:0] wb_q[$];       // write buffer {be, addr, data}
  logic [31:0] rd_q[$];       // pending read addresses
  logic [31:0] mem [0:15];    // slave RAM, word-indexed from BASE
  int accept_log[$];

  int rdelay = 2;
  int wdelay = 2;
  int busy_cnt = 0;
  int cycle = 0;
  int wb_pop_cycles = 0;
  int rd_valid_cycles = 0;
  int rd_strobe_cycles = 0;
  int wr_strobe_cycles = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mips_avalon_arbiter #(.READ_BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_addr(wb_addr), .wb_writedata(wb_writedata), .wb_byteenable(wb_byteenable),
    .wb_write(wb_write), .wb_empty(wb_empty), .wb_waitrequest(wb_waitrequest),
    .rd_addr(rd_addr), .rd_read(rd_read), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readvalid(rd_readvalid),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  // Slave: stalls for wdelay/rdelay cycles, then accepts.
  assign avm_waitrequest = (busy_cnt < (avm_write ? wdelay : rdelay));
  assign avm_readdata    = mem[avm_address[3:0]];

  // ---------------- drivers, slave and monitor ----------------
  initial begin : bus_loop
    logic s_wb_pop, s_rd_pop, s_wr_acc, s_strobe, s_acc;
    logic [31:0] s_addr, s_data;
    logic [3:0] s_be;
    logic hold_valid;
    logic [72:0] hold_val;
    hold_valid = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    wb_write = 1'b0; wb_empty = 1'b1; wb_addr = '0; wb_writedata = '0; wb_byteenable = '0;
    rd_read = 1'b0; rd_addr = '0;
    forever begin
      @(negedge clk);
      cycle++;
      s_wb_pop = !wb_waitrequest;
      s_rd_pop = !rd_waitrequest;
      s_strobe = avm_read || avm_write;
      s_acc    = s_strobe && !avm_waitrequest;
      s_wr_acc = avm_write && !avm_waitrequest;
      s_addr   = avm_address;
      s_data   = avm_writedata;
      s_be     = avm_byteenable;
      if (rst) begin
        hold_valid = 1'b0;
      end else begin
        if (s_strobe) begin
          if (avm_read) rd_strobe_cycles++;
          if (avm_write) wr_strobe_cycles++;
          checks++;
          if (avm_read && avm_write) begin
            errors++;
            $display("FAIL both_strobes: read=%b write=%b, required one-hot", avm_read, avm_write);
          end
          if (hold_valid) begin
            checks++;
            if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} !== hold_val) begin
              errors++;
              $display("FAIL hold_stable: got %h required %h",
                       {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable}, hold_val);
            end
          end
          if (avm_waitrequest) begin
            hold_valid = 1'b1;
            hold_val = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
          end else begin
            hold_valid = 1'b0;
            accept_log.push_back(cycle);
            checks++;
            if (exp_op_q.size() == 0) begin
              errors++;
              $display("FAIL bus_op: got %h, required no transfer", {avm_write, avm_address});
            end else begin
              logic [32:0] e;
              e = exp_op_q.pop_front();
              if ({avm_write, avm_address} !== e) begin
                errors++;
                $display("FAIL bus_op: got %h required %h", {avm_write, avm_address}, e);
              end
            end
          end
        end else begin
          hold_valid = 1'b0;
        end
        if (!wb_waitrequest) wb_pop_cycles++;
        if (rd_readvalid) begin
          rd_valid_cycles++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_data: got %h, required no rd_readvalid", rd_readdata);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rd_readdata !== e) begin
              errors++;
              $display("FAIL rd_data: got %h required %h", rd_readdata, e);
            end
          end
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (s_wb_pop && wb_q.size() != 0) void'(wb_q.pop_front());
        if (s_rd_pop && rd_q.size() != 0) void'(rd_q.pop_front());
        if (s_wr_acc) begin
          for (int b = 0; b < 4; b++)
            if (s_be[b]) mem[s_addr[3:0]][8*b +: 8] = s_data[8*b +: 8];
        end
        if (s_strobe && !s_acc) busy_cnt++;
        else busy_cnt = 0;
      end
      wb_write = (wb_q.size() != 0);
      wb_empty = (wb_q.size() == 0);
      if (wb_q.size() != 0) {wb_byteenable, wb_addr, wb_writedata} = wb_q[0];
      else {wb_byteenable, wb_addr, wb_writedata} = '0;
      rd_read = (rd_q.size() != 0);
      rd_addr = (rd_q.size() != 0) ? rd_q[0] : 32'h0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    wb_q.push_back({be, addr, data});
    exp_op_q.push_back({1'b1, addr});
  endtask

  task automatic push_read(input logic [31:0] addr, input logic [31:0] exp_data);
    rd_q.push_back(addr);
    exp_q.push_back(exp_data);
    exp_op_q.push_back({1'b0, addr});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((wb_q.size() != 0 || rd_q.size() != 0 || exp_q.size() != 0 ||
            exp_op_q.size() != 0 || avm_read || avm_write) && n < 400) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: %0d ops / %0d reads outstanding, required 0", name, exp_op_q.size(), exp_q.size());
      wb_q.delete(); rd_q.delete(); exp_q.delete(); exp_op_q.delete();
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (avm_read !== 1'b0)      begin errors++; $display("FAIL rst_avm_read: got %b required 0", avm_read); end
    if (avm_write !== 1'b0)     begin errors++; $display("FAIL rst_avm_write: got %b required 0", avm_write); end
    if (avm_address !== 32'h0)  begin errors++; $display("FAIL rst_avm_address: got %h required 0", avm_address); end
    if (avm_writedata !== 32'h0) begin errors++; $display("FAIL rst_avm_writedata: got %h required 0", avm_writedata); end
    if (avm_byteenable !== 4'h0) begin errors++; $display("FAIL rst_avm_byteenable: got %h required 0", avm_byteenable); end
    if (rd_readdata !== 32'h0)  begin errors++; $display("FAIL rst_rd_readdata: got %h required 0", rd_readdata); end
    if (rd_readvalid !== 1'b0)  begin errors++; $display("FAIL rst_rd_readvalid: got %b required 0", rd_readvalid); end
    if (wb_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wb_waitrequest: got %b required 1", wb_waitrequest); end
    if (rd_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_rd_waitrequest: got %b required 1", rd_waitrequest); end
    #2 rst = 1'b0;
    @(negedge clk); #2;
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    int pops0 = wb_pop_cycles;
    wdelay = 2;
    push_write(BASE + 32'd4, 32'hDEAD0004, 4'hF);
    while (!avm_write && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (avm_write !== 1'b1) begin errors++; $display("FAIL midrst_start: avm_write=%b required 1", avm_write); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 4;
    if (avm_write !== 1'b0) begin errors++; $display("FAIL midrst_write: got %b required 0", avm_write); end
    if (avm_read !== 1'b0)  begin errors++; $display("FAIL midrst_read: got %b required 0", avm_read); end
    if (wb_waitrequest !== 1'b1) begin errors++; $display("FAIL midrst_waitreq: got %b required 1", wb_waitrequest); end
    if (wb_q.size() != 1) begin errors++; $display("FAIL midrst_nopop: buffer holds %0d required 1", wb_q.size()); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_idle("midrst");
    checks += 2;
    if (mem[4] !== 32'hDEAD0004) begin errors++; $display("FAIL midrst_reissue: mem=%h required deadbeef-like %h", mem[4], 32'hDEAD0004); end
    if (wb_pop_cycles - pops0 != 1) begin errors++; $display("FAIL midrst_pops: got %0d required 1", wb_pop_cycles - pops0); end
  endtask

  task automatic test_write_before_read();
    for (int i = 0; i < 8; i++) push_write(BASE + 32'(i), 32'(i * i), 4'hF);
    push_read(BASE + 32'd3, 32'd9);
    wait_idle("wr_before_rd");
  endtask

  task automatic test_single_read();
    int strobes0 = rd_strobe_cycles;
    int valid0 = rd_valid_cycles;
    rdelay = 2;
    push_read(BASE + 32'd2, 32'd4);
    wait_idle("single_read");
    checks += 2;
    if (rd_strobe_cycles - strobes0 != 3) begin errors++; $display("FAIL read_strobe_len: got %0d required 3", rd_strobe_cycles - strobes0); end
    if (rd_valid_cycles - valid0 != 1) begin errors++; $display("FAIL readvalid_pulses: got %0d required 1", rd_valid_cycles - valid0); end
  endtask

  task automatic test_write_stall();
    int pops0 = wb_pop_cycles;
    int strobes0 = wr_strobe_cycles;
    wdelay = 5;
    push_write(BASE + 32'd5, 32'h5A5A0005, 4'hF);
    wait_idle("write_stall");
    wdelay = 2;
    checks += 3;
    if (wb_pop_cycles - pops0 != 1) begin errors++; $display("FAIL stall_pops: got %0d required 1", wb_pop_cycles - pops0); end
    if (wr_strobe_cycles - strobes0 != 6) begin errors++; $display("FAIL stall_len: got %0d required 6", wr_strobe_cycles - strobes0); end
    if (mem[5] !== 32'h5A5A0005) begin errors++; $display("FAIL stall_data: got %h required %h", mem[5], 32'h5A5A0005); end
  endtask

  task automatic test_byteenable();
    push_write(BASE + 32'd1, 32'h11111111, 4'hF);
    wait_idle("be_prefill");
    push_write(BASE + 32'd1, 32'hAABBCCDD, 4'b0011);
    wait_idle("be_write");
    push_read(BASE + 32'd1, (32'h11111111 & 32'hFFFF0000) | (32'hAABBCCDD & 32'h0000FFFF));
    wait_idle("be_read");
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4];
    rdelay = 0;
    wdelay = 0;
    accept_log.delete();
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom_range(32'hFFFF, 1) * 32'd65537;
      push_write(BASE + 32'(i), data[i], 4'hF);
    end
    wait_idle("b2b_write");
    checks++;
    if (accept_log.size() != 4 || accept_log[3] - accept_log[0] != 6) begin
      errors++;
      $display("FAIL b2b_write_spacing: %0d transfers, span %0d, required 4 transfers span 6",
               accept_log.size(), accept_log.size() == 4 ? accept_log[3] - accept_log[0] : -1);
    end
    accept_log.delete();
    for (int i = 0; i < 4; i++) push_read(BASE + 32'(i), data[i]);
    wait_idle("b2b_read");
    checks++;
    if (accept_log.size() != 4 || accept_log[3] - accept_log[0] != 6) begin
      errors++;
      $display("FAIL b2b_read_spacing: %0d transfers, span %0d, required 4 transfers span 6",
               accept_log.size(), accept_log.size() == 4 ? accept_log[3] - accept_log[0] : -1);
    end
    rdelay = 2;
    wdelay = 2;
  endtask

`ifdef MIPS_ARB_READ_PRIORITY_EN
  task automatic test_read_priority();
    int rd_k = 0;
    int wr_k = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #2;
    // Ten reads and two writes presented together: R,R,R,R,W,R,R,R,R,W,R,R.
    for (int i = 0; i < 10; i++) rd_q.push_back(BASE + 32'd8 + 32'(i % 8));
    for (int i = 0; i < 10; i++) exp_q.push_back(32'hC0DE0008 + 32'(i % 8));
    wb_q.push_back({4'hF, BASE + 32'd6, 32'h66666666});
    wb_q.push_back({4'hF, BASE + 32'd7, 32'h77777777});
    for (int g = 0; g < 12; g++) begin
      if (g == 4 || g == 9) begin
        exp_op_q.push_back({1'b1, BASE + 32'd6 + 32'(wr_k)});
        wr_k++;
      end else begin
        exp_op_q.push_back({1'b0, BASE + 32'd8 + 32'(rd_k % 8)});
        rd_k++;
      end
    end
    wait_idle("read_priority");
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    test_reset();
    test_reset_mid_write();
`ifndef MIPS_ARB_READ_PRIORITY_EN
    test_write_before_read();
`endif
    test_single_read();
    test_write_stall();
    test_byteenable();
    test_back_to_back();
`ifdef MIPS_ARB_READ_PRIORITY_EN
    test_read_priority();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
